// File: rtl/pm_apb_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : pm_apb_sequencer
// Purpose  : APB initiator for one process-monitor measurement. On a start
//            pulse it writes the reference counter, writes sensor control
//            with the run bit forced high, then polls sensor status until
//            the slave accepts a read (or the poll budget runs out).
// Ports    : pclk/presetn        - clock, asynchronous active-low reset
//            start               - single-cycle request, honoured in IDLE only
//            ref_count_in        - measurement window (reference clocks)
//            sensor_ctrl_in      - sensor selection field
//            busy/apb_enable     - sequence in progress
//            done/err/err_code   - completion pulse and held result code
//            status_out          - last accepted status word
//            psel..pwdata        - APB master request
//            prdata/pready/pslverr - APB slave response
// Revision : 1.0 - initial release
// ============================================================================
module pm_apb_sequencer #(
  parameter int                ADDR_W         = 5,
  parameter int                DATA_W         = 32,
  parameter int                CTRL_W         = 16,
  parameter logic [ADDR_W-1:0] SENS_CTRL_ADDR = 5'b00100,
  parameter logic [ADDR_W-1:0] REF_CNT_ADDR   = 5'b01000,
  parameter logic [ADDR_W-1:0] SENS_STAT_ADDR = 5'b01100,
  parameter int                RUN_BIT        = 10,
  parameter int                POLL_GAP       = 8,
  parameter int                MAX_POLLS      = 1024
) (
  input  logic              pclk,
  input  logic              presetn,
  input  logic              start,
  input  logic [DATA_W-1:0] ref_count_in,
  input  logic [CTRL_W-1:0] sensor_ctrl_in,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [DATA_W-1:0] status_out,
  output logic              apb_enable,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  localparam int POLL_W = $clog2(MAX_POLLS + 1);
  localparam int GAP_W  = $clog2(POLL_GAP + 1);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SETUP  = 3'd1;
  localparam logic [2:0] ST_ACCESS = 3'd2;
  localparam logic [2:0] ST_GAP    = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  localparam logic [1:0] STEP_REF  = 2'd0;
  localparam logic [1:0] STEP_CTRL = 2'd1;
  localparam logic [1:0] STEP_STAT = 2'd2;

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_REF     = 2'b01;
  localparam logic [1:0] ERR_CTRL    = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  logic [2:0]        r_state;
  logic [1:0]        r_step;
  logic [POLL_W-1:0] r_poll_cnt;
  logic [GAP_W-1:0]  r_gap_cnt;
  logic [DATA_W-1:0] r_ref;
  logic [CTRL_W-1:0] r_ctrl;

  logic [2:0]        w_state_nxt;
  logic [1:0]        w_step_nxt;
  logic [POLL_W-1:0] w_poll_nxt;
  logic [POLL_W-1:0] w_poll_inc;
  logic [GAP_W-1:0]  w_gap_nxt;
  logic [DATA_W-1:0] w_ref_nxt;
  logic [CTRL_W-1:0] w_ctrl_nxt;
  logic [1:0]        w_err_code_nxt;
  logic [DATA_W-1:0] w_status_nxt;
  logic              w_xfer_done;

  logic              w_psel_nxt;
  logic              w_pwrite_nxt;
  logic [ADDR_W-1:0] w_paddr_nxt;
  logic [DATA_W-1:0] w_pwdata_nxt;
  logic [DATA_W-1:0] w_ctrl_word;

  // A transfer completes only in a real ACCESS phase with the slave ready.
  assign w_xfer_done = (r_state == ST_ACCESS) & psel & penable & pready;
  assign w_poll_inc  = r_poll_cnt + POLL_W'(1);

  always_comb begin
    w_state_nxt    = r_state;
    w_step_nxt     = r_step;
    w_poll_nxt     = r_poll_cnt;
    w_gap_nxt      = r_gap_cnt;
    w_ref_nxt      = r_ref;
    w_ctrl_nxt     = r_ctrl;
    w_err_code_nxt = err_code;
    w_status_nxt   = status_out;

    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_ref_nxt      = ref_count_in;
          w_ctrl_nxt     = sensor_ctrl_in;
          w_step_nxt     = STEP_REF;
          w_poll_nxt     = '0;
          w_err_code_nxt = ERR_OK;
          w_state_nxt    = ST_SETUP;
        end
      end

      ST_SETUP: w_state_nxt = ST_ACCESS;

      ST_ACCESS: begin
        if (w_xfer_done) begin
          case (r_step)
            STEP_REF: begin
              if (pslverr) begin
                w_err_code_nxt = ERR_REF;
                w_state_nxt    = ST_DONE;
              end else begin
                w_step_nxt  = STEP_CTRL;
                w_state_nxt = ST_SETUP;
              end
            end
            STEP_CTRL: begin
              if (pslverr) begin
                w_err_code_nxt = ERR_CTRL;
                w_state_nxt    = ST_DONE;
              end else begin
                w_step_nxt  = STEP_STAT;
                w_state_nxt = ST_SETUP;
              end
            end
            STEP_STAT: begin
              if (!pslverr) begin
                w_status_nxt   = prdata;
                w_err_code_nxt = ERR_OK;
                w_state_nxt    = ST_DONE;
              end else begin
                w_poll_nxt = w_poll_inc;
                if (w_poll_inc == POLL_W'(MAX_POLLS)) begin
                  w_err_code_nxt = ERR_TIMEOUT;
                  w_state_nxt    = ST_DONE;
                end else begin
                  // Loaded with N-1 so that GAP lasts exactly POLL_GAP cycles.
                  w_gap_nxt   = GAP_W'(POLL_GAP - 1);
                  w_state_nxt = ST_GAP;
                end
              end
            end
            default: w_state_nxt = ST_IDLE;
          endcase
        end
      end

      ST_GAP: begin
        if (r_gap_cnt == '0) begin
          w_state_nxt = ST_SETUP;
        end else begin
          w_gap_nxt = r_gap_cnt - GAP_W'(1);
        end
      end

      ST_DONE: w_state_nxt = ST_IDLE;

      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Control word: zero-extended selection field with the run bit forced on.
  always_comb begin
    w_ctrl_word               = '0;
    w_ctrl_word[CTRL_W-1:0]   = w_ctrl_nxt;
    w_ctrl_word[RUN_BIT]      = 1'b1;
  end

  // APB request is decoded from the next state so that every APB output
  // comes straight from a flop and lines up with the state it belongs to.
  always_comb begin
    w_psel_nxt   = (w_state_nxt == ST_SETUP) || (w_state_nxt == ST_ACCESS);
    w_pwrite_nxt = 1'b0;
    w_paddr_nxt  = '0;
    w_pwdata_nxt = '0;
    if (w_psel_nxt) begin
      case (w_step_nxt)
        STEP_REF: begin
          w_pwrite_nxt = 1'b1;
          w_paddr_nxt  = REF_CNT_ADDR;
          w_pwdata_nxt = w_ref_nxt;
        end
        STEP_CTRL: begin
          w_pwrite_nxt = 1'b1;
          w_paddr_nxt  = SENS_CTRL_ADDR;
          w_pwdata_nxt = w_ctrl_word;
        end
        default: begin
          w_paddr_nxt  = SENS_STAT_ADDR;
        end
      endcase
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_state    <= ST_IDLE;
      r_step     <= STEP_REF;
      r_poll_cnt <= '0;
      r_gap_cnt  <= '0;
      r_ref      <= '0;
      r_ctrl     <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      err_code   <= ERR_OK;
      status_out <= '0;
      psel       <= 1'b0;
      penable    <= 1'b0;
      pwrite     <= 1'b0;
      paddr      <= '0;
      pwdata     <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_step     <= w_step_nxt;
      r_poll_cnt <= w_poll_nxt;
      r_gap_cnt  <= w_gap_nxt;
      r_ref      <= w_ref_nxt;
      r_ctrl     <= w_ctrl_nxt;
      busy       <= (w_state_nxt == ST_SETUP) || (w_state_nxt == ST_ACCESS) ||
                    (w_state_nxt == ST_GAP);
      done       <= (w_state_nxt == ST_DONE);
      err        <= (w_err_code_nxt != ERR_OK);
      err_code   <= w_err_code_nxt;
      status_out <= w_status_nxt;
      psel       <= w_psel_nxt;
      penable    <= (w_state_nxt == ST_ACCESS);
      pwrite     <= w_pwrite_nxt;
      paddr      <= w_paddr_nxt;
      pwdata     <= w_pwdata_nxt;
    end
  end

  assign apb_enable = busy;

endmodule
`default_nettype wire

// File: tb/tb_pm_apb_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_pm_apb_sequencer
// Purpose  : Self-checking bench for pm_apb_sequencer. A small APB slave model
//            answers the requests; expected transfers and completions are
//            queued when each run is launched and compared as they appear.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pm_apb_sequencer;

  localparam int POLL_GAP  = 8;
  localparam int MAX_POLLS = 4;

  logic        pclk = 1'b0;
  logic        presetn = 1'b0;
  logic        start = 1'b0;
  logic [31:0] ref_count_in = '0;
  logic [15:0] sensor_ctrl_in = '0;
  logic        busy, done, err, apb_enable, psel, penable, pwrite;
  logic [1:0]  err_code;
  logic [31:0] status_out, pwdata, prdata;
  logic [4:0]  paddr;
  logic        pready, pslverr;

  pm_apb_sequencer #(
    .POLL_GAP  (POLL_GAP),
    .MAX_POLLS (MAX_POLLS)
  ) dut (
    .pclk           (pclk),
    .presetn        (presetn),
    .start          (start),
    .ref_count_in   (ref_count_in),
    .sensor_ctrl_in (sensor_ctrl_in),
    .busy           (busy),
    .done           (done),
    .err            (err),
    .err_code       (err_code),
    .status_out     (status_out),
    .apb_enable     (apb_enable),
    .psel           (psel),
    .penable        (penable),
    .pwrite         (pwrite),
    .paddr          (paddr),
    .pwdata         (pwdata),
    .prdata         (prdata),
    .pready         (pready),
    .pslverr        (pslverr)
  );

  always #5 pclk = ~pclk;

  // ---------------- slave model ----------------
  int          s_wait = 0;
  logic        s_rej_ref = 1'b0;
  logic        s_rej_ctrl = 1'b0;
  int          s_rej_stat = 0;
  logic [31:0] s_rdata = '0;
  int          wcnt = 0;
  int          stat_seen = 0;

  assign pready  = psel & penable & (wcnt >= s_wait);
  assign pslverr = pready & (((paddr == 5'h08) & s_rej_ref) |
                             ((paddr == 5'h04) & s_rej_ctrl) |
                             ((paddr == 5'h0C) & (stat_seen < s_rej_stat)));
  assign prdata  = pslverr ? 32'hBAD0_BAD0 : s_rdata;

  always @(posedge pclk) begin
    if (psel & penable & !pready) wcnt <= wcnt + 1;
    else                          wcnt <= 0;
    if (start)                              stat_seen <= 0;
    else if (pready && (paddr == 5'h0C))    stat_seen <= stat_seen + 1;
  end

  // ---------------- scoreboard ----------------
  typedef struct { logic w; logic [4:0] a; logic [31:0] d; } xfer_t;
  typedef struct { int c; logic e; logic [1:0] code; logic [31:0] st; } done_t;
  xfer_t xq[$];
  done_t dq[$];
  done_t d_exp;

  int cyc = 0, t0 = 0, run_len = 0, done_cnt = 0, idle_run = 0;
  logic run_active = 1'b0;
  int n_checks = 0, n_errors = 0;

  always @(posedge pclk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic push_x(input logic w, input logic [4:0] a, input logic [31:0] d);
    xfer_t x;
    x.w = w; x.a = a; x.d = d;
    xq.push_back(x);
  endtask

  task automatic push_d(input int c, input logic e, input logic [1:0] code, input logic [31:0] st);
    done_t d;
    d.c = c; d.e = e; d.code = code; d.st = st;
    dq.push_back(d);
  endtask

  always @(negedge pclk) begin
    if (presetn) begin
      logic exp_busy;
      exp_busy = run_active && ((cyc - t0) >= 1) && ((cyc - t0) < run_len);
      check("busy", 64'(busy), 64'(exp_busy));
      check("apb_enable", 64'(apb_enable), 64'(exp_busy));

      if (!psel) begin
        check("idle_bus_zero", 64'({pwrite, paddr, pwdata}), 64'(0));
        if (busy) idle_run++;
      end else begin
        if (!penable) begin
          if (paddr == 5'h0C && idle_run > 0) check("poll_gap", 64'(idle_run), 64'(POLL_GAP));
          idle_run = 0;
        end
        if (xq.size() == 0) begin
          check("xfer_unexpected", 64'(1), 64'(0));
        end else begin
          check(penable ? "access_sig" : "setup_sig",
                64'({pwrite, paddr, pwdata}), 64'({xq[0].w, xq[0].a, xq[0].d}));
          if (penable && pready) void'(xq.pop_front());
        end
      end

      if (done) begin
        done_cnt++;
        if (dq.size() == 0) begin
          check("done_unexpected", 64'(1), 64'(0));
        end else begin
          d_exp = dq.pop_front();
          check("done_cycle", 64'(cyc - t0), 64'(d_exp.c));
          check("done_err", 64'(err), 64'(d_exp.e));
          check("done_err_code", 64'(err_code), 64'(d_exp.code));
          check("done_status", 64'(status_out), 64'(d_exp.st));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic start_run(input logic [31:0] rc, input logic [15:0] sc, input int len);
    @(posedge pclk); #1;
    ref_count_in   = rc;
    sensor_ctrl_in = sc;
    start          = 1'b1;
    t0             = cyc;
    run_len        = len;
    run_active     = 1'b1;
    @(posedge pclk); #1;
    start          = 1'b0;
    // Scramble inputs: the block must use its latched copies.
    ref_count_in   = 32'hFFFF_FFFF;
    sensor_ctrl_in = 16'h5A5A;
  endtask

  task automatic wait_done(input int target, input int limit);
    int i;
    i = 0;
    while (done_cnt < target && i < limit) begin
      @(negedge pclk);
      i++;
    end
    check("run_finished", 64'(done_cnt), 64'(target));
  endtask

  initial begin
    repeat (3) @(posedge pclk);
    #1;
    check("rst_ctrl", 64'({busy, done, err, err_code, apb_enable, psel, penable, pwrite, paddr}), 64'(0));
    check("rst_data", {status_out, pwdata}, 64'(0));
    #2 presetn = 1'b1;

    // Zero-wait run
    s_rdata = 32'hABCD_1234;
    push_x(1'b1, 5'h08, 32'h0000_1000);
    push_x(1'b1, 5'h04, 32'h0000_0403);
    push_x(1'b0, 5'h0C, 32'h0);
    push_d(7, 1'b0, 2'b00, 32'hABCD_1234);
    start_run(32'h0000_1000, 16'h0003, 7);
    wait_done(1, 50);

    // Three rejected polls, fourth accepted
    s_rej_stat = 3;
    s_rdata    = 32'h1357_9BDF;
    push_x(1'b1, 5'h08, 32'h0000_0200);
    push_x(1'b1, 5'h04, 32'h0000_0401);
    for (int i = 0; i < 4; i++) push_x(1'b0, 5'h0C, 32'h0);
    push_d(37, 1'b0, 2'b00, 32'h1357_9BDF);
    start_run(32'h0000_0200, 16'h0001, 37);
    wait_done(2, 100);

    // Status always rejected: timeout after MAX_POLLS reads
    s_rej_stat = 1000;
    s_rdata    = 32'h0F0F_0F0F;
    push_x(1'b1, 5'h08, 32'h0000_0300);
    push_x(1'b1, 5'h04, 32'h0000_0402);
    for (int i = 0; i < MAX_POLLS; i++) push_x(1'b0, 5'h0C, 32'h0);
    push_d(37, 1'b1, 2'b11, 32'h1357_9BDF);
    start_run(32'h0000_0300, 16'h0002, 37);
    wait_done(3, 100);
    repeat (3) @(negedge pclk);
    check("err_held", 64'({err, err_code}), 64'({1'b1, 2'b11}));
    check("status_held", 64'(status_out), 64'(32'h1357_9BDF));

    // Control write rejected
    s_rej_stat = 0;
    s_rej_ctrl = 1'b1;
    push_x(1'b1, 5'h08, 32'h0000_0055);
    push_x(1'b1, 5'h04, 32'h0000_0400);
    push_d(5, 1'b1, 2'b10, 32'h1357_9BDF);
    start_run(32'h0000_0055, 16'h0400, 5);
    wait_done(4, 50);
    s_rej_ctrl = 1'b0;

    // Reference write rejected
    s_rej_ref = 1'b1;
    push_x(1'b1, 5'h08, 32'h0000_0066);
    push_d(3, 1'b1, 2'b01, 32'h1357_9BDF);
    start_run(32'h0000_0066, 16'h0007, 3);
    wait_done(5, 50);
    s_rej_ref = 1'b0;

    // Two wait states per ACCESS, stray start at cycle 4
    s_wait  = 2;
    s_rdata = 32'h2468_ACE0;
    push_x(1'b1, 5'h08, 32'hDEAD_0001);
    push_x(1'b1, 5'h04, 32'h0000_8401);
    push_x(1'b0, 5'h0C, 32'h0);
    push_d(13, 1'b0, 2'b00, 32'h2468_ACE0);
    start_run(32'hDEAD_0001, 16'h8001, 13);
    repeat (3) @(posedge pclk);
    #1 start = 1'b1;
    @(posedge pclk);
    #1 start = 1'b0;
    wait_done(6, 100);
    repeat (20) @(negedge pclk);
    check("no_extra_done", 64'(done_cnt), 64'(6));

    // Reset pulsed at cycle 3 of a run
    s_wait = 0;
    push_x(1'b1, 5'h08, 32'h0000_0077);
    start_run(32'h0000_0077, 16'h0002, 1000);
    @(posedge pclk);
    @(posedge pclk);
    #2 presetn = 1'b0;
    run_active = 1'b0;
    #1;
    check("async_rst_ctrl", 64'({busy, done, err, err_code, apb_enable, psel, penable, pwrite, paddr}), 64'(0));
    check("async_rst_data", {status_out, pwdata}, 64'(0));
    #4 presetn = 1'b1;
    repeat (20) @(negedge pclk);
    check("no_done_after_rst", 64'(done_cnt), 64'(6));
    check("xfer_queue_empty", 64'(xq.size()), 64'(0));
    check("done_queue_empty", 64'(dq.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Global safety net in case the sequence itself stalls.
  initial begin
    #200000;
    $display("FAIL global_timeout: got=running expected=finished");
    $fatal(1, "global timeout");
  end

endmodule
`default_nettype wire

// File: doc/pm_apb_sequencer.md
# pm_apb_sequencer

APB initiator that drives one measurement on the process-monitor sensor controller's APB register interface. On a `start` pulse it writes the reference counter, then writes sensor control with the run bit set, then polls sensor status until the slave accepts the read. It returns the status word or an error code. It sits between the SoC power-management control logic and the sensor controller's APB slave port, on the same `pclk` domain.

## Interface
- `ADDR_W`, 5, APB address width.
- `DATA_W`, 32, APB data width.
- `CTRL_W`, 16, sensor control field width.
- `SENS_CTRL_ADDR`, 5'b00100, sensor control register address.
- `REF_CNT_ADDR`, 5'b01000, reference counter register address.
- `SENS_STAT_ADDR`, 5'b01100, sensor status register address.
- `RUN_BIT`, 10, index of the run bit inside sensor control.
- `POLL_GAP`, 8, idle cycles between status polls (≥1).
- `MAX_POLLS`, 1024, maximum status read attempts before timeout (≥1).

Ports:
- `pclk` in 1: clock.
- `presetn` in 1: asynchronous, active-low reset.
- `start` in 1: single-cycle request; sampled only in IDLE.
- `ref_count_in` in DATA_W: time window, in reference clock cycles.
- `sensor_ctrl_in` in CTRL_W: sensor selection; bit RUN_BIT is forced to 1 on write.
- `busy` out 1: high from the cycle after an accepted start until DONE.
- `done` out 1: one-cycle completion pulse.
- `err` out 1: valid with `done`; held until the next accepted start.
- `err_code` out 2: 00 ok, 01 reference write slverr, 10 control write slverr, 11 poll timeout; held like `err`.
- `status_out` out DATA_W: last accepted status word; held.
- `apb_enable` out 1: equals `busy`.
- `psel`, `penable`, `pwrite` out 1: APB master controls.
- `paddr` out ADDR_W, `pwdata` out DATA_W: APB address and write data.
- `prdata` in DATA_W, `pready` in 1, `pslverr` in 1: APB slave response.

## Operation
- FSM states: IDLE, SETUP, ACCESS, GAP, DONE. A step register selects REF, CTRL or STAT.
- IDLE + `start`: latch `ref_count_in` and `sensor_ctrl_in`, set step=REF, clear poll counter, go to SETUP.
- SETUP drives `psel=1`, `penable=0`, plus `paddr`/`pwrite`/`pwdata` for the current step:
  - REF: write, `pwdata` = latched ref count.
  - CTRL: write, `pwdata` = zero-extended latched ctrl with bit RUN_BIT=1.
  - STAT: read, `pwdata`=0.
- SETUP always goes to ACCESS.
- ACCESS holds all SETUP signals with `penable=1` and stays there while `pready=0`. On `pready=1` the transfer completes:
  - REF, `pslverr=0`: step=CTRL → SETUP. `pslverr=1`: `err_code`=01 → DONE.
  - CTRL, `pslverr=0`: step=STAT → SETUP. `pslverr=1`: `err_code`=10 → DONE.
  - STAT, `pslverr=0`: `status_out` <= `prdata`, `err_code`=00 → DONE.
  - STAT, `pslverr=1`: poll counter +1. If the counter reaches MAX_POLLS, `err_code`=11 → DONE. Otherwise → GAP.
- GAP: all APB outputs low for POLL_GAP cycles (down-counter), then → SETUP.
- DONE: `done=1` for one cycle, `busy=0`, → IDLE.
- `start` outside IDLE is ignored; no queueing.
- `start` in the DONE cycle is ignored.
- Poll counter width is clog2(MAX_POLLS+1); no wrap.
- `paddr`/`pwdata`/`pwrite` are 0 whenever `psel=0`.

## Timing
- All outputs are registered. Reset values: every output 0, FSM=IDLE, counters 0, `status_out`=0.
- Zero-wait-state run, with cycle 0 = `start` high:
  - Cycles 1–2: REF SETUP/ACCESS.
  - Cycles 3–4: CTRL.
  - Cycles 5–6: STAT.
  - Cycle 7: `done`.
  - `busy` is high in cycles 1–6.
- Each slave wait state adds one cycle. Each rejected poll adds 2+POLL_GAP cycles.
- Transfers run back-to-back: the next SETUP follows ACCESS completion directly.
- `pslverr` and `prdata` are sampled only when `psel & penable & pready`.
- `presetn` asserted mid-transfer: `psel`/`penable` drop asynchronously, FSM returns to IDLE, no `done` is issued. After release the block waits for a new `start`.

## Test plan
- Zero-wait slave, ref=0x0000_1000, ctrl=0x0003: APB writes 0x08←0x1000, then 0x04←0x0403, then read 0x0C returns 0xABCD_1234. `done` in cycle 7, `status_out`=0xABCD_1234, `err_code`=00.
- Slave rejects the first 3 status reads with POLL_GAP=8: 4 reads total, 8 idle cycles with `psel=0` between each, `done` in cycle 37, `err`=0.
- Slave always rejects status with MAX_POLLS=4: exactly 4 reads, then `done` with `err_code`=11 and `status_out` unchanged from its previous value.
- `pslverr` on the control write: no status read is issued, `done` the cycle after the control ACCESS, `err_code`=10. Same check for the reference write gives 01.
- `pready` low for 2 cycles in each ACCESS: SETUP signals stay stable throughout, `done` in cycle 13. A `start` pulse at cycle 4 is ignored. `presetn` pulsed low at cycle 3 of a second run: all outputs 0 immediately and no `done` afterward.
